// File: rtl/arm_cpu_pkg.sv
// Shared definitions for the ARM CPU front end.
// Contents: datapath word width, PC increment, default reset PC,
// the fetch FSM state encoding and a word-alignment helper.
package arm_cpu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] PC_INCR      = 32'd4;
    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        ADDR_S  = 3'd0,
        READ_S  = 3'd1,
        LATCH_S = 3'd2,
        HOLD_S  = 3'd3,
        FAULT_S = 3'd4
    } fetch_state_e;

    // Instruction addresses are always word aligned.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// 8-bit saturating cycle counter used to bound the wait for memory completion.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - synchronous clear to zero (has priority over en_i)
//   en_i        - count up by one, saturating at 8'hFF
//   expired_o   - count has reached LIMIT-1
module fetch_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetches 32-bit words through MAR/MDR, holds them in
// the instruction register and hands them to the decoder with valid/ready.
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   mar_en, mem_addr              - load MAR with the current PC
//   ram_en, mfc, mem_rdata        - RAM read request / completion / data
//   mdr_en                        - load MDR from mem_rdata
//   instRegister_en               - load instruction register
//   instruction, pc_out           - held word and its address
//   instr_valid, instr_ready      - decoder handshake
//   branch_valid, branch_target   - PC redirect
//   fetch_fault                   - sticky memory-timeout flag
module instruction_fetch_unit
    import arm_cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned       MFC_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mar_en,
    output logic [WORD_W-1:0] mem_addr,
    output logic              ram_en,
    input  logic              mfc,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mdr_en,
    output logic              instRegister_en,
    output logic [WORD_W-1:0] instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] pc_out,
    input  logic              branch_valid,
    input  logic [WORD_W-1:0] branch_target,
    output logic              fetch_fault
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] mdr_q, mdr_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] pc_out_q, pc_out_d;
    logic              discard_q, discard_d;
    logic              fault_q, fault_d;

    logic              mar_c, ram_c, mdr_c, ir_c;
    logic              tmo_clr, tmo_en, tmo_expired;
    logic [WORD_W-1:0] branch_pc;

    assign branch_pc = word_align(branch_target);

    fetch_timeout_counter #(
        .LIMIT(MFC_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (tmo_clr),
        .en_i     (tmo_en),
        .expired_o(tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mdr_d     = mdr_q;
        ir_d      = ir_q;
        pc_out_d  = pc_out_q;
        discard_d = discard_q;
        fault_d   = fault_q;
        mar_c     = 1'b0;
        ram_c     = 1'b0;
        mdr_c     = 1'b0;
        ir_c      = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;

        unique case (state_q)
            ADDR_S: begin
                mar_c   = 1'b1;
                tmo_clr = 1'b1;
                if (branch_valid) begin
                    pc_d    = branch_pc;
                    state_d = ADDR_S;
                end else begin
                    state_d = READ_S;
                end
            end
            READ_S: begin
                ram_c = 1'b1;
                // The bus transaction is never aborted: a redirect only marks
                // the in-flight word for discard; the last target wins.
                if (branch_valid) begin
                    pc_d      = branch_pc;
                    discard_d = 1'b1;
                end
                if (mfc) begin
                    mdr_c   = 1'b1;
                    mdr_d   = mem_rdata;
                    state_d = LATCH_S;
                end else if (tmo_expired) begin
                    fault_d = 1'b1;
                    state_d = FAULT_S;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            LATCH_S: begin
                if (branch_valid) begin
                    pc_d      = branch_pc;
                    discard_d = 1'b0;
                    state_d   = ADDR_S;
                end else if (discard_q) begin
                    discard_d = 1'b0;
                    state_d   = ADDR_S;
                end else begin
                    ir_c     = 1'b1;
                    ir_d     = mdr_q;
                    pc_out_d = pc_q;
                    pc_d     = pc_q + PC_INCR;
                    state_d  = HOLD_S;
                end
            end
            HOLD_S: begin
                // A redirect wins over a same-cycle consume.
                if (branch_valid) begin
                    pc_d    = branch_pc;
                    state_d = ADDR_S;
                end else if (instr_ready) begin
                    state_d = ADDR_S;
                end
            end
            FAULT_S: begin
                if (branch_valid) begin
                    pc_d      = branch_pc;
                    fault_d   = 1'b0;
                    discard_d = 1'b0;
                    state_d   = ADDR_S;
                end
            end
            default: state_d = ADDR_S;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ADDR_S;
            pc_q      <= RESET_PC;
            mdr_q     <= '0;
            ir_q      <= '0;
            pc_out_q  <= '0;
            discard_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mdr_q     <= mdr_d;
            ir_q      <= ir_d;
            pc_out_q  <= pc_out_d;
            discard_q <= discard_d;
            fault_q   <= fault_d;
        end
    end

    // Reset parks the FSM in ADDR_S, whose strobe would otherwise be high;
    // gating keeps every enable low while rst_n is asserted.
    assign mar_en          = mar_c & rst_n;
    assign ram_en          = ram_c & rst_n;
    assign mdr_en          = mdr_c & rst_n;
    assign instRegister_en = ir_c & rst_n;
    assign instr_valid     = (state_q == HOLD_S) & rst_n;
    assign mem_addr        = pc_q;
    assign instruction     = ir_q;
    assign pc_out          = pc_out_q;
    assign fetch_fault     = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by a randomized run checked against a transaction-level address model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mar_en;
    logic [31:0] mem_addr;
    logic        ram_en;
    logic        mfc;
    logic [31:0] mem_rdata;
    logic        mdr_en;
    logic        instRegister_en;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    // Memory responder configuration: fixed latency (-1 = never completes)
    // or a random 0..3 latency per transaction.
    int          mem_lat  = 0;
    bit          rand_lat = 0;
    int          cur_lat  = 0;
    int          waited   = 0;
    logic [31:0] req_addr = '0;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .MFC_TIMEOUT(16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mar_en         (mar_en),
        .mem_addr       (mem_addr),
        .ram_en         (ram_en),
        .mfc            (mfc),
        .mem_rdata      (mem_rdata),
        .mdr_en         (mdr_en),
        .instRegister_en(instRegister_en),
        .instruction    (instruction),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .pc_out         (pc_out),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfun(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hE081_2003;
    endfunction

    // MAR capture on the clock edge, like the real address register.
    always @(posedge clk) begin
        if (mar_en) begin
            req_addr = mem_addr;
            waited   = 0;
            cur_lat  = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
        end
    end

    always @(negedge clk) begin
        if (ram_en && cur_lat >= 0 && waited == cur_lat) begin
            mfc       = 1'b1;
            mem_rdata = memfun(req_addr);
        end else begin
            mfc       = 1'b0;
            mem_rdata = $urandom;
            if (ram_en) waited++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          idx;
        bit          found, saw_ir, saw_valid;
        bit          br, rdy;
        logic [31:0] tgt;
        logic [31:0] exp_addr;
        int          words;

        rst_n         = 1'b0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_target = '0;
        mfc           = 1'b0;
        mem_rdata     = '0;

        // Reset state
        step();
        step();
        chk("rst_mar_en", mar_en, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_mem_addr", mem_addr, 0);

        // First fetch, zero-wait memory
        rst_n = 1'b1;
        #1;
        chk("c0_mar_en", mar_en, 1);
        chk("c0_mem_addr", mem_addr, 0);
        instr_ready = 1'b1;
        step();
        chk("c1_ram_en", ram_en, 1);
        chk("c1_mdr_en", mdr_en, 1);
        step();
        chk("c2_ir_en", instRegister_en, 1);
        chk("c2_valid", instr_valid, 0);
        step();
        chk("c3_valid", instr_valid, 1);
        chk("c3_instruction", instruction, 32'hE081_2003);
        chk("c3_pc_out", pc_out, 0);
        step();
        chk("c4_mar_en", mar_en, 1);
        chk("c4_mem_addr", mem_addr, 32'h4);
        chk("c4_valid", instr_valid, 0);

        // Stall in HOLD_S with ready low
        instr_ready = 1'b0;
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", instr_valid, 1);
            chk("stall_instruction", instruction, memfun(32'h4));
            chk("stall_pc_out", pc_out, 32'h4);
            chk("stall_no_mar", mar_en, 0);
            step();
        end
        instr_ready = 1'b1;
        mem_lat     = 3;
        step();
        chk("stall_next_mar", mar_en, 1);
        chk("stall_next_addr", mem_addr, 32'h8);

        // Redirect during READ_S with a slow memory
        step();
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        branch_valid = 1'b0;
        chk("rd_br_mem_addr", mem_addr, 32'h100);
        chk("rd_br_ram_en", ram_en, 1);
        found = 0; saw_ir = 0; saw_valid = 0; idx = 0;
        for (int i = 0; i < 12; i++) begin
            if (mar_en) begin
                found = 1;
                idx   = i;
                break;
            end
            if (instRegister_en) saw_ir = 1;
            if (instr_valid) saw_valid = 1;
            step();
        end
        chk("rd_br_refetch", found, 1);
        chk("rd_br_refetch_cycle", idx, 4);
        chk("rd_br_no_ir_load", saw_ir, 0);
        chk("rd_br_no_valid", saw_valid, 0);
        chk("rd_br_addr", mem_addr, 32'h100);
        mem_lat = 0;
        step();
        step();
        step();
        chk("rd_br_valid", instr_valid, 1);
        chk("rd_br_pc_out", pc_out, 32'h100);
        chk("rd_br_instruction", instruction, memfun(32'h100));

        // Branch and ready in the same HOLD_S cycle
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0200;
        step();
        branch_valid = 1'b0;
        chk("hold_br_mar", mar_en, 1);
        chk("hold_br_addr", mem_addr, 32'h200);
        chk("hold_br_valid", instr_valid, 0);
        step();
        step();
        step();
        chk("hold_br_pc_out", pc_out, 32'h200);
        chk("hold_br_instruction", instruction, memfun(32'h200));

        // MFC timeout
        mem_lat = -1;
        step();
        chk("tmo_addr", mem_addr, 32'h204);
        step();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!ram_en) break;
            n++;
            step();
        end
        chk("tmo_read_cycles", n, 16);
        chk("tmo_fault", fetch_fault, 1);
        chk("tmo_mar", mar_en, 0);
        repeat (3) step();
        chk("tmo_fault_held", fetch_fault, 1);
        chk("tmo_valid", instr_valid, 0);
        chk("tmo_ram_en", ram_en, 0);
        chk("tmo_mar_held", mar_en, 0);
        branch_valid  = 1'b1;
        branch_target = 32'h0000_0040;
        mem_lat       = 0;
        step();
        branch_valid = 1'b0;
        chk("tmo_clear", fetch_fault, 0);
        chk("tmo_exit_mar", mar_en, 1);
        chk("tmo_exit_addr", mem_addr, 32'h40);

        // PC wrap at the top of the address space
        branch_valid  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        step();
        branch_valid = 1'b0;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        chk("wrap_mar", mar_en, 1);
        step();
        step();
        step();
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_instruction", instruction, memfun(32'hFFFF_FFFC));
        step();
        chk("wrap_next_addr", mem_addr, 32'h0);
        chk("wrap_next_mar", mar_en, 1);

        // Asynchronous reset in the middle of a read
        mem_lat = -1;
        step();
        step();
        chk("mrst_pre_ram_en", ram_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_ram_en", ram_en, 0);
        chk("mrst_mar_en", mar_en, 0);
        chk("mrst_pc_out", pc_out, 0);
        chk("mrst_instruction", instruction, 0);
        chk("mrst_valid", instr_valid, 0);
        chk("mrst_mem_addr", mem_addr, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mrst_restart_mar", mar_en, 1);
        chk("mrst_restart_addr", mem_addr, 0);

        // Randomized run: every presented word must come from the address the
        // program flow predicts (sequential, or the latest redirect target).
        rand_lat = 1;
        exp_addr = 32'h0;
        words    = 0;
        for (int i = 0; i < 400; i++) begin
            if (instr_valid) begin
                words++;
                chk("rnd_pc_out", pc_out, exp_addr);
                chk("rnd_instruction", instruction, memfun(exp_addr));
            end
            chk("rnd_no_fault", fetch_fault, 0);
            br  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = $urandom;
            if (br) exp_addr = tgt & ~32'h3;
            else if (instr_valid && rdy) exp_addr = exp_addr + 32'd4;
            branch_valid  = br;
            branch_target = tgt;
            instr_ready   = rdy;
            step();
        end
        branch_valid = 1'b0;
        chk("rnd_progress", (words > 20) ? 32'd1 : 32'd0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Upstream stage of instruction_decoder. Fetches 32-bit ARM instruction words from RAM through the MAR/MDR path and holds the word in the instruction register. Presents the word to the decoder with a valid/ready handshake, then advances the PC by 4. Also handles PC redirects from branch resolution and flags memory timeouts when MFC (memory function complete) never arrives.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
MFC_TIMEOUT, 16, max cycles in READ waiting for mfc before fault; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset; asynchronous, active-low.
mar_en  output  1  load MAR with mem_addr this cycle.
mem_addr  output  32  fetch address (current PC).
ram_en  output  1  RAM read request; held until mfc.
mfc  input  1  memory function complete; mem_rdata valid this cycle.
mem_rdata  input  32  RAM read data.
mdr_en  output  1  load MDR from mem_rdata.
instRegister_en  output  1  load instruction register.
instruction  output  32  instruction register contents, to decoder.
instr_valid  output  1  instruction holds an unconsumed word.
instr_ready  input  1  decoder accepts instruction this cycle.
pc_out  output  32  address of the word in instruction.
branch_valid  input  1  redirect request.
branch_target  input  32  redirect address; bits [1:0] ignored (forced 00).
fetch_fault  output  1  sticky; MFC timeout occurred.

Behaviour:
- Async reset (rst_n low): state=ADDR_S, PC=RESET_PC, instruction=0, pc_out=0, all enables/instr_valid/fetch_fault=0, timeout count=0, discard flag=0. Takes effect immediately, including mid-read. RAM must tolerate ram_en dropping without mfc.
- States: ADDR_S, READ_S, LATCH_S, HOLD_S, FAULT_S.
- ADDR_S: mar_en=1, mem_addr=PC, one cycle -> READ_S, count=0.
- READ_S: ram_en=1, mem_addr=PC. If mfc: mdr_en=1 -> LATCH_S. Else count++. If count reaches MFC_TIMEOUT-1 without mfc: fetch_fault=1 -> FAULT_S.
- LATCH_S: instRegister_en=1; instruction<=mem_rdata (registered from MDR capture); pc_out<=PC; PC<=PC+4 (mod 2^32, wraps FFFF_FFFC->0000_0000) -> HOLD_S. If discard flag set: no IR load, PC unchanged, clear flag -> ADDR_S.
- HOLD_S: instr_valid=1, instruction/pc_out stable. If instr_ready: -> ADDR_S, instr_valid low next cycle.
- Latency: with zero-wait memory (mfc in first READ cycle), instr_valid rises 3 cycles after entering ADDR_S. Throughput: one instruction per 4 cycles with ready held high.
- Branch priority (branch_valid sampled each edge):
  - ADDR_S/HOLD_S/LATCH_S: PC<=branch_target&~3; instr_valid=0 next cycle; -> ADDR_S. Held word is dropped even if instr_ready is high the same cycle (branch wins).
  - READ_S: memory transaction is never aborted. PC<=target, discard flag=1, continue waiting. On mfc the word is thrown away.
  - FAULT_S: branch clears fetch_fault, PC<=target -> ADDR_S.
- Multiple branches during one READ_S: the last target wins.
- FAULT_S: all enables 0, instr_valid=0; exits only via branch_valid or reset.
- mfc outside READ_S is ignored.

Decomposition:
- Shared package arm_cpu_pkg:
  - fetch state enum (3 bits).
  - PC_INCR=4.
  - WORD_W=32.
  - RESET_PC default.
- One sub-module: fetch_timeout_counter (8-bit saturating counter with clear/enable/expired). The FSM, PC register and IR stay in the top module.

Test Plan:
- Reset release, zero-wait memory returning 32'hE0812003 at addr 0, ready=1 -> mar_en cycle 0, ram_en cycle 1, instr_valid cycle 3 with instruction=E0812003, pc_out=0; next fetch addr=4.
- instr_ready=0 for 5 cycles in HOLD_S -> instruction/pc_out stable, no mar_en; ready=1 -> next mem_addr=PC+4.
- branch_valid with target 32'h0000_0103 during READ_S (mfc delayed 3 cycles) -> returned word discarded, no instr_valid, next mem_addr=0000_0100.
- branch_valid and instr_ready same cycle in HOLD_S -> word not consumed, next fetch from target.
- mfc never asserted, MFC_TIMEOUT=16 -> fetch_fault=1 after 16 READ_S cycles, FAULT_S held; branch_valid to 0x40 -> fault clears, fetch at 0x40.
- PC=FFFF_FFFC fetch -> next mem_addr=0000_0000. rst_n low mid-READ_S -> outputs zero immediately, restart at RESET_PC.
